// File: rtl/viterbi_pkg.sv
// Shared types and constants for the hard-decision K=3 Viterbi decoder:
// controller state encoding, default frame geometry and trellis node labels.
package viterbi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACS    = 3'd1,
      ST_SELECT = 3'd2,
      ST_TRBK   = 3'd3,
      ST_OUT    = 3'd4
   } state_t;

   localparam int FRAME_LEN_DEF    = 8;
   localparam int SM_AW_DEF        = 3;
   localparam int TRBK_TIMEOUT_DEF = 16;
   localparam int FCNT_W_DEF       = 16;

   // Trellis nodes shared by ACS and traceback.
   localparam logic [1:0] S0 = 2'b00;
   localparam logic [1:0] S1 = 2'b01;
   localparam logic [1:0] S2 = 2'b10;
   localparam logic [1:0] S3 = 2'b11;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/viterbi_frame_ctrl_if.sv
// Symbol-stream, ACS/survivor/traceback control and output handshake bundle
// of the Viterbi frame controller; master is the controller side.
interface viterbi_frame_ctrl_if
   import viterbi_pkg::*;
#(
   parameter int SM_AW  = SM_AW_DEF,
   parameter int FCNT_W = FCNT_W_DEF
);
   logic              i_sym_valid;
   logic              o_sym_ready;
   logic              o_acs_en;
   logic              o_acs_clr;
   logic              o_sm_wr_en;
   logic [SM_AW-1:0]  o_sm_wr_addr;
   logic [SM_AW-1:0]  o_sm_rd_addr;
   logic              o_slt_load;
   logic              o_en_trbk;
   logic              i_trbk_done;
   logic              o_out_valid;
   logic              i_out_ready;
   logic              o_busy;
   logic              o_err;
   logic [FCNT_W-1:0] o_frame_cnt;

   modport master (
      input  i_sym_valid, i_trbk_done, i_out_ready,
      output o_sym_ready, o_acs_en, o_acs_clr, o_sm_wr_en, o_sm_wr_addr,
             o_sm_rd_addr, o_slt_load, o_en_trbk, o_out_valid, o_busy,
             o_err, o_frame_cnt
   );

   modport slave (
      output i_sym_valid, i_trbk_done, i_out_ready,
      input  o_sym_ready, o_acs_en, o_acs_clr, o_sm_wr_en, o_sm_wr_addr,
             o_sm_rd_addr, o_slt_load, o_en_trbk, o_out_valid, o_busy,
             o_err, o_frame_cnt
   );
endinterface

// File: rtl/viterbi_stage_cnt.sv
// Loadable up/down stage counter that saturates at both ends and flags
// when the count equals a supplied terminal value.
module viterbi_stage_cnt #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic         dn,
   input  logic [W-1:0] tc_val,
   output logic [W-1:0] cnt,
   output logic         tc
);
   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
   localparam logic [W-1:0] CNT_MIN = {W{1'b0}};

   logic [W-1:0] cnt_r;
   logic [W-1:0] cnt_s;

   // Next count: load has priority, otherwise step toward the saturating bound.
   always_comb begin
      cnt_s = cnt_r;
      if (load) begin
         cnt_s = load_val;
      end else if (en && dn && (cnt_r != CNT_MIN)) begin
         cnt_s = cnt_r - W'(1);
      end else if (en && !dn && (cnt_r != CNT_MAX)) begin
         cnt_s = cnt_r + W'(1);
      end else begin
         cnt_s = cnt_r;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_r <= CNT_MIN;
      end else begin
         cnt_r <= cnt_s;
      end
   end

   assign cnt = cnt_r;
   assign tc  = (cnt_r == tc_val);

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the K=3 Viterbi decoder: steps ACS/survivor writes over
// FRAME_LEN symbols, then drives best-node select, traceback and byte output.
module viterbi_frame_ctrl
   import viterbi_pkg::*;
#(
   parameter int FRAME_LEN    = FRAME_LEN_DEF,
   parameter int SM_AW        = SM_AW_DEF,
   parameter int TRBK_TIMEOUT = TRBK_TIMEOUT_DEF,
   parameter int FCNT_W       = FCNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   viterbi_frame_ctrl_if.master bus
);
   localparam int               TMO_W    = cnt_width(TRBK_TIMEOUT);
   localparam logic [SM_AW-1:0] LAST_IDX = SM_AW'(FRAME_LEN - 1);
   localparam logic [SM_AW-1:0] IDX_ZERO = {SM_AW{1'b0}};
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TRBK_TIMEOUT - 1);
   localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};

   state_t            state_r;
   state_t            state_s;
   logic              sym_ready_s;
   logic              accept_s;
   logic              last_sym_s;
   logic              tmo_hit_s;
   logic              rd_zero_s;
   logic              frame_done_s;
   logic              timeout_s;
   logic              wr_load_s;
   logic [SM_AW-1:0]  wr_cnt_s;
   logic [SM_AW-1:0]  rd_cnt_s;
   logic [TMO_W-1:0]  tmo_cnt_s;
   logic [FCNT_W-1:0] frame_cnt_r;
   logic              err_r;

   // Ready only depends on state and reset, never on the output handshake.
   assign sym_ready_s  = rst & ((state_r == ST_IDLE) | (state_r == ST_ACS));
   assign accept_s     = sym_ready_s & bus.i_sym_valid;
   assign frame_done_s = (state_r == ST_TRBK) & bus.i_trbk_done;
   assign timeout_s    = (state_r == ST_TRBK) & ~bus.i_trbk_done & tmo_hit_s;
   assign wr_load_s    = (accept_s & last_sym_s) | ~((state_r == ST_IDLE) | (state_r == ST_ACS));

   viterbi_stage_cnt #(.W(SM_AW)) u_wr_cnt (
      .clk(clk), .rst(rst), .load(wr_load_s), .load_val(IDX_ZERO),
      .en(accept_s), .dn(1'b0), .tc_val(LAST_IDX), .cnt(wr_cnt_s), .tc(last_sym_s)
   );

   viterbi_stage_cnt #(.W(SM_AW)) u_rd_cnt (
      .clk(clk), .rst(rst), .load(state_r == ST_SELECT), .load_val(LAST_IDX),
      .en((state_r == ST_TRBK) & ~rd_zero_s), .dn(1'b1), .tc_val(IDX_ZERO),
      .cnt(rd_cnt_s), .tc(rd_zero_s)
   );

   viterbi_stage_cnt #(.W(TMO_W)) u_tmo_cnt (
      .clk(clk), .rst(rst), .load(state_r == ST_SELECT), .load_val(TMO_ZERO),
      .en(state_r == ST_TRBK), .dn(1'b0), .tc_val(TMO_LAST),
      .cnt(tmo_cnt_s), .tc(tmo_hit_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; a done in the timeout cycle still completes the frame.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && last_sym_s) state_s = ST_SELECT;
            else if (accept_s)          state_s = ST_ACS;
            else                        state_s = ST_IDLE;
         end
         ST_ACS: begin
            if (accept_s && last_sym_s) state_s = ST_SELECT;
            else                        state_s = ST_ACS;
         end
         ST_SELECT: state_s = ST_TRBK;
         ST_TRBK: begin
            if (bus.i_trbk_done) state_s = ST_OUT;
            else if (tmo_hit_s)  state_s = ST_IDLE;
            else                 state_s = ST_TRBK;
         end
         ST_OUT: begin
            if (bus.i_out_ready) state_s = ST_IDLE;
            else                 state_s = ST_OUT;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Strobes and addresses decoded from state and counters, silenced in reset.
   always_comb begin
      bus.o_sym_ready  = sym_ready_s;
      bus.o_acs_en     = accept_s;
      bus.o_acs_clr    = accept_s & (state_r == ST_IDLE);
      bus.o_sm_wr_en   = accept_s;
      bus.o_sm_wr_addr = wr_cnt_s;
      bus.o_slt_load   = rst & (state_r == ST_SELECT);
      bus.o_en_trbk    = rst & (state_r == ST_TRBK);
      bus.o_out_valid  = rst & (state_r == ST_OUT);
      bus.o_busy       = rst & (state_r != ST_IDLE);
      bus.o_err        = err_r;
      bus.o_frame_cnt  = frame_cnt_r;
      if (state_r == ST_TRBK) begin
         bus.o_sm_rd_addr = rd_cnt_s;
      end else begin
         bus.o_sm_rd_addr = IDX_ZERO;
      end
   end

   // Completed-frame counter and sticky traceback-timeout flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         frame_cnt_r <= {FCNT_W{1'b0}};
         err_r       <= 1'b0;
      end else begin
         if (frame_done_s) frame_cnt_r <= frame_cnt_r + FCNT_W'(1);
         else              frame_cnt_r <= frame_cnt_r;
         if (timeout_s) err_r <= 1'b1;
         else           err_r <= err_r;
      end
   end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Self-checking bench for viterbi_frame_ctrl: scenario table drives whole
// frames, per-cycle expectations go through a scoreboard queue.
module tb_viterbi_frame_ctrl;
   localparam int FL = 8;

   logic clk;
   logic rst;

   viterbi_frame_ctrl_if #(.SM_AW(3), .FCNT_W(16)) bus ();

   viterbi_frame_ctrl #(
      .FRAME_LEN(8), .SM_AW(3), .TRBK_TIMEOUT(16), .FCNT_W(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Expected vector: {sym_ready, acs_en, acs_clr, wr_en, slt_load, en_trbk,
   //                   out_valid, busy, err, wr_addr[3], rd_addr[3], frame_cnt[16]}
   typedef struct {
      logic [30:0] val;
      logic [30:0] mask;
      string       name;
   } sb_t;

   typedef struct {
      int          bub_at;
      int          bub_len;
      int          done_at;
      int          rdy_wait;
      int          rst_at;
      logic [15:0] exp_fcnt;
      logic        exp_err;
   } scen_t;

   sb_t         sbq[$];
   scen_t       tbl[9];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] prev_fcnt;
   logic        prev_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [30:0] ex(input logic sr, input logic ae, input logic ac,
                                      input logic we, input logic sl, input logic et,
                                      input logic ov, input logic bz, input logic er,
                                      input logic [2:0] wa, input logic [2:0] ra,
                                      input logic [15:0] fc);
      return {sr, ae, ac, we, sl, et, ov, bz, er, wa, ra, fc};
   endfunction

   function automatic logic [30:0] mk(input logic cwa, input logic cra, input logic cst);
      return {8'hFF, cst, (cwa ? 3'b111 : 3'b000), (cra ? 3'b111 : 3'b000),
              (cst ? 16'hFFFF : 16'h0000)};
   endfunction

   task automatic step(input logic v, input logic d, input logic r, input logic rs,
                       input logic [30:0] ev, input logic [30:0] em, input string nm);
      sb_t e;
      @(posedge clk);
      #1;
      bus.i_sym_valid = v;
      bus.i_trbk_done = d;
      bus.i_out_ready = r;
      rst             = rs;
      e.val  = ev;
      e.mask = em;
      e.name = nm;
      sbq.push_back(e);
   endtask

   // Compare each queued expectation against the DUT mid-cycle.
   always @(negedge clk) begin : monitor
      sb_t         e;
      logic [30:0] act;
      if (sbq.size() > 0) begin
         e   = sbq.pop_front();
         act = {bus.o_sym_ready, bus.o_acs_en, bus.o_acs_clr, bus.o_sm_wr_en,
                bus.o_slt_load, bus.o_en_trbk, bus.o_out_valid, bus.o_busy,
                bus.o_err, bus.o_sm_wr_addr, bus.o_sm_rd_addr, bus.o_frame_cnt};
         n_tests++;
         if (((act ^ e.val) & e.mask) !== 31'd0) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (mask %h)", e.name, act, e.val, e.mask);
         end
      end
   end

   task automatic run(input scen_t sc, input int id);
      logic  d;
      string tag;
      tag = $sformatf("s%0d", id);
      for (int i = 0; i < FL; i++) begin
         if (i == sc.bub_at) begin
            for (int b = 0; b < sc.bub_len; b++) begin
               step(1'b0, 1'b0, 1'b0, 1'b1,
                    ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, prev_err,
                       3'd0, 3'd0, prev_fcnt),
                    mk(1'b0, 1'b0, 1'b1), {tag, "_bubble"});
            end
         end
         if (i == sc.rst_at) begin
            step(1'b1, 1'b0, 1'b0, 1'b0,
                 ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    3'd0, 3'd0, 16'd0),
                 mk(1'b0, 1'b0, 1'b0), {tag, "_rst_cycle"});
            step(1'b0, 1'b0, 1'b0, 1'b1,
                 ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    3'd0, 3'd0, 16'd0),
                 mk(1'b1, 1'b1, 1'b1), {tag, "_after_rst"});
            return;
         end
         step(1'b1, 1'b0, 1'b0, 1'b1,
              ex(1'b1, 1'b1, (i == 0), 1'b1, 1'b0, 1'b0, 1'b0, (i > 0), prev_err,
                 3'(i), 3'd0, prev_fcnt),
              mk(1'b1, 1'b0, 1'b1), $sformatf("%s_sym%0d", tag, i));
      end
      // Symbols offered during select/traceback/output must be refused.
      step(1'b1, 1'b0, 1'b0, 1'b1,
           ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, prev_err,
              3'd0, 3'd0, prev_fcnt),
           mk(1'b0, 1'b0, 1'b1), {tag, "_select"});
      d = 1'b0;
      for (int k = 0; k < 16 && !d; k++) begin
         d = (sc.done_at == k + 1);
         step(1'b1, d, 1'b0, 1'b1,
              ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, prev_err,
                 3'd0, (k < 7) ? 3'(7 - k) : 3'd0, prev_fcnt),
              mk(1'b0, 1'b1, 1'b1), $sformatf("%s_trbk%0d", tag, k));
      end
      if (d) begin
         for (int w = 0; w <= sc.rdy_wait; w++) begin
            step(1'b1, 1'b1, (w == sc.rdy_wait), 1'b1,
                 ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, prev_err,
                    3'd0, 3'd0, sc.exp_fcnt),
                 mk(1'b0, 1'b0, 1'b1), $sformatf("%s_out%0d", tag, w));
         end
      end
      step(1'b0, 1'b0, 1'b0, 1'b1,
           ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sc.exp_err,
              3'd0, 3'd0, sc.exp_fcnt),
           mk(1'b0, 1'b0, 1'b1), {tag, "_idle"});
   endtask

   initial begin
      // bub_at, bub_len, done_at (0 = never), rdy_wait, rst_at, end frame_cnt, end err
      tbl[0] = '{bub_at: -1, bub_len: 0, done_at: 1,  rdy_wait: 0, rst_at: -1, exp_fcnt: 16'd1, exp_err: 1'b0};
      tbl[1] = '{bub_at: 4,  bub_len: 3, done_at: 3,  rdy_wait: 1, rst_at: -1, exp_fcnt: 16'd2, exp_err: 1'b0};
      tbl[2] = '{bub_at: -1, bub_len: 0, done_at: 9,  rdy_wait: 5, rst_at: -1, exp_fcnt: 16'd3, exp_err: 1'b0};
      tbl[3] = '{bub_at: -1, bub_len: 0, done_at: 0,  rdy_wait: 0, rst_at: -1, exp_fcnt: 16'd3, exp_err: 1'b1};
      tbl[4] = '{bub_at: 2,  bub_len: 1, done_at: 2,  rdy_wait: 0, rst_at: -1, exp_fcnt: 16'd4, exp_err: 1'b1};
      tbl[5] = '{bub_at: -1, bub_len: 0, done_at: 16, rdy_wait: 2, rst_at: -1, exp_fcnt: 16'd5, exp_err: 1'b1};
      tbl[6] = '{bub_at: -1, bub_len: 0, done_at: 1,  rdy_wait: 0, rst_at: 5,  exp_fcnt: 16'd0, exp_err: 1'b0};
      tbl[7] = '{bub_at: -1, bub_len: 0, done_at: 1,  rdy_wait: 0, rst_at: -1, exp_fcnt: 16'd1, exp_err: 1'b0};
      tbl[8] = '{bub_at: -1, bub_len: 0, done_at: 1,  rdy_wait: 0, rst_at: -1, exp_fcnt: 16'd0, exp_err: 1'b0};

      rst             = 1'b0;
      bus.i_sym_valid = 1'b0;
      bus.i_trbk_done = 1'b0;
      bus.i_out_ready = 1'b0;

      step(1'b1, 1'b0, 1'b0, 1'b0,
           ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'd0),
           mk(1'b1, 1'b1, 1'b1), "reset");
      step(1'b0, 1'b0, 1'b0, 1'b1,
           ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'd0),
           mk(1'b1, 1'b1, 1'b1), "idle_after_reset");

      prev_fcnt = 16'd0;
      prev_err  = 1'b0;
      for (int s = 0; s < 9; s++) begin
         if (s == 8) begin
            @(negedge clk);
            #1;
            force dut.frame_cnt_r = 16'hFFFF;
            #1;
            release dut.frame_cnt_r;
            prev_fcnt = 16'hFFFF;
         end
         run(tbl[s], s);
         prev_fcnt = tbl[s].exp_fcnt;
         prev_err  = tbl[s].exp_err;
      end

      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (bus.o_frame_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL final_wrap: frame_cnt %h expected 0000", bus.o_frame_cnt);
      end
      n_tests++;
      if (bus.o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL final_idle: busy %b expected 0", bus.o_busy);
      end
      n_tests++;
      if (bus.o_err !== 1'b0) begin
         n_fail++;
         $display("FAIL final_err: err %b expected 0", bus.o_err);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      if (n_fail == 0) $display("PASS");
      else             $display("FAIL");
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
      $fatal(1, "watchdog expired");
   end

endmodule
